// File: rtl/gradient_sequencer.sv
// Valve/pump timing controller for a two-inlet serpentine gradient network.
// Sequence: prime, one dwell per selected outlet, flush, then a single done cycle.
module gradient_sequencer #(
    parameter int unsigned N_OUT = 10,
    parameter int unsigned CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CW-1:0]    prime_len,
    input  logic [CW-1:0]    dwell_len,
    input  logic [CW-1:0]    flush_len,
    input  logic [N_OUT-1:0] out_mask,
    output logic             inlet_a_en,
    output logic             inlet_b_en,
    output logic [N_OUT-1:0] outlet_open,
    output logic             sample_strobe,
    output logic [3:0]       cur_outlet,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {StIdle, StPrime, StDwell, StFlush, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_OUT-1:0]  mask_q, mask_d;
    logic [CW-1:0]     dwell_q, dwell_d;
    logic [CW-1:0]     flush_q, flush_d;
    logic [3:0]        cur_d;
    logic              inlet_a_d, inlet_b_d, strobe_d, busy_d, done_d, err_d;
    logic [N_OUT-1:0]  open_d;
    logic [4:0]        first_bit, next_bit;

    function automatic logic [CW-1:0] eff_len(input logic [CW-1:0] v);
        return (v == '0) ? CW'(1) : v;
    endfunction

    // Lowest set mask bit strictly above 'from'; bit 4 of the result flags a hit.
    function automatic logic [4:0] find_above(input logic [N_OUT-1:0] m, input int from);
        logic [4:0] r;
        r = '0;
        for (int i = int'(N_OUT) - 1; i >= 0; i--) begin
            if (m[i] && (i > from)) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    assign first_bit = find_above(mask_q, -1);
    assign next_bit  = find_above(mask_q, int'(cur_outlet));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        flush_d = flush_q;
        cur_d   = cur_outlet;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (|out_mask) begin
                        state_d = StPrime;
                        cnt_d   = eff_len(prime_len);
                        mask_d  = out_mask;
                        dwell_d = dwell_len;
                        flush_d = flush_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPrime: begin
                if (abort) begin
                    state_d = StFlush;
                    cnt_d   = eff_len(flush_q);
                end else if (cnt_q <= CW'(1)) begin
                    state_d = StDwell;
                    cur_d   = first_bit[3:0];
                    cnt_d   = eff_len(dwell_q);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StDwell: begin
                if (abort) begin
                    state_d = StFlush;
                    cnt_d   = eff_len(flush_q);
                end else if (cnt_q <= CW'(1)) begin
                    if (next_bit[4]) begin
                        cur_d = next_bit[3:0];
                        cnt_d = eff_len(dwell_q);
                    end else begin
                        state_d = StFlush;
                        cnt_d   = eff_len(flush_q);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StFlush: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (state_d != StDwell) cur_d = '0;
    end

    // Outputs are decoded from the next state so every output leaves a flop.
    always_comb begin
        inlet_a_d = 1'b0;
        inlet_b_d = 1'b0;
        open_d    = '0;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != StIdle);
        unique case (state_d)
            StPrime: begin
                inlet_a_d = 1'b1;
                inlet_b_d = 1'b1;
                open_d    = '1;
            end
            StDwell: begin
                inlet_a_d = 1'b1;
                inlet_b_d = 1'b1;
                open_d    = N_OUT'(1) << cur_d;
                strobe_d  = (cnt_d == CW'(1));
            end
            StFlush: begin
                inlet_a_d = 1'b1;
                open_d    = '1;
            end
            StDone: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            mask_q        <= '0;
            dwell_q       <= '0;
            flush_q       <= '0;
            cur_outlet    <= '0;
            inlet_a_en    <= 1'b0;
            inlet_b_en    <= 1'b0;
            outlet_open   <= '0;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            dwell_q       <= dwell_d;
            flush_q       <= flush_d;
            cur_outlet    <= cur_d;
            inlet_a_en    <= inlet_a_d;
            inlet_b_en    <= inlet_b_d;
            outlet_open   <= open_d;
            sample_strobe <= strobe_d;
            busy          <= busy_d;
            done          <= done_d;
            err           <= err_d;
        end
    end

endmodule
